// File: rtl/r16_pipe_ctrl_pkg.sv
// Shared types and defaults for the radix-16 modular pipeline sequencer.
package r16_pipe_ctrl_pkg;

    localparam int R16_WIDTH  = 64;
    localparam int R16_STAGES = 4;
    localparam int R16_GRP    = 16;
    localparam int R16_GCNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/r16_pipe_ctrl_if.sv
// Control/handshake bundle between the feeder/writeback side and the sequencer.
interface r16_pipe_ctrl_if
    import r16_pipe_ctrl_pkg::*;
#(
    parameter int P_WIDTH  = R16_WIDTH,
    parameter int P_STAGES = R16_STAGES,
    parameter int P_GCNT_W = R16_GCNT_W
);
    logic                start;
    logic [P_WIDTH-1:0]  mod_in;
    logic [P_GCNT_W-1:0] num_grp;
    logic                in_valid;
    logic                in_ready;
    logic                out_ready;
    logic                out_valid;
    logic [P_STAGES-1:0] stage_en;
    logic [P_STAGES-1:0] stage_vld;
    logic [P_WIDTH-1:0]  mod_out;
    logic                sog;
    logic                eog;
    logic                busy;
    logic                done;

    modport master (
        output start, mod_in, num_grp, in_valid, out_ready,
        input  in_ready, out_valid, stage_en, stage_vld,
        input  mod_out, sog, eog, busy, done
    );

    modport slave (
        input  start, mod_in, num_grp, in_valid, out_ready,
        output in_ready, out_valid, stage_en, stage_vld,
        output mod_out, sog, eog, busy, done
    );
endinterface

// File: rtl/r16_pipe_vld_chain.sv
// Bubble-collapsing enable/valid chain for the controlled register stages.
module r16_pipe_vld_chain
    import r16_pipe_ctrl_pkg::*;
#(
    parameter int P_STAGES = R16_STAGES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                accept,
    input  logic                out_ready,
    output logic [P_STAGES-1:0] stage_en,
    output logic [P_STAGES-1:0] stage_vld
);

    // A stage may load if it is empty or everything ahead of it moves.
    always_comb begin
        logic run;
        run      = out_ready;
        stage_en = '0;
        for (int i = P_STAGES - 1; i >= 0; i--) begin
            run         = ~stage_vld[i] | run;
            stage_en[i] = run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld <= '0;
        end else begin
            if (stage_en[0])
                stage_vld[0] <= accept;
            for (int i = 1; i < P_STAGES; i++)
                if (stage_en[i])
                    stage_vld[i] <= stage_vld[i-1];
        end
    end

endmodule

// File: rtl/r16_pipe_ctrl.sv
// Batch sequencer: FSM, operand counters, modulus broadcast and group markers.
module r16_pipe_ctrl
    import r16_pipe_ctrl_pkg::*;
#(
    parameter int P_WIDTH  = R16_WIDTH,
    parameter int P_STAGES = R16_STAGES,
    parameter int P_GRP    = R16_GRP,
    parameter int P_GCNT_W = R16_GCNT_W
) (
    input logic            clk,
    input logic            rst_n,
    r16_pipe_ctrl_if.slave bus
);

    localparam int LG = $clog2(P_GRP);
    localparam int TW = P_GCNT_W + LG;

    state_t              state;
    state_t              state_nxt;
    logic [P_GCNT_W-1:0] grp_q;
    logic [P_WIDTH-1:0]  mod_q;
    logic [TW-1:0]       total;
    logic [TW-1:0]       last_idx;
    logic [TW-1:0]       in_cnt;
    logic [TW-1:0]       out_cnt;
    logic [TW-1:0]       grp_pos;
    logic [P_STAGES-1:0] stage_en;
    logic [P_STAGES-1:0] stage_vld;
    logic                in_ready;
    logic                out_valid;
    logic                accept;
    logic                out_hs;
    logic                last_in;
    logic                last_out;
    logic                take;
    logic                done;

    assign total     = TW'(grp_q) << LG;
    assign last_idx  = total - TW'(1);
    assign in_ready  = (state == ST_RUN) & stage_en[0];
    assign accept    = bus.in_valid & in_ready;
    assign out_valid = stage_vld[P_STAGES-1];
    assign out_hs    = out_valid & bus.out_ready;
    assign last_in   = accept & (in_cnt == last_idx);
    assign last_out  = out_hs & (out_cnt == last_idx);
    assign take      = (state == ST_IDLE) & bus.start;
    assign grp_pos   = out_cnt & TW'(P_GRP - 1);

    r16_pipe_vld_chain #(
        .P_STAGES (P_STAGES)
    ) u_chain (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (accept),
        .out_ready (bus.out_ready),
        .stage_en  (stage_en),
        .stage_vld (stage_vld)
    );

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start)
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (total == '0) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_in)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_out) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_q   <= '0;
            mod_q   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (take) begin
            grp_q   <= bus.num_grp;
            mod_q   <= bus.mod_in;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (accept)
                in_cnt <= in_cnt + TW'(1);
            if (out_hs)
                out_cnt <= out_cnt + TW'(1);
        end
    end

    // Enables are forced low while reset is held so no stage loads garbage.
    assign bus.stage_en  = rst_n ? stage_en : '0;
    assign bus.stage_vld = stage_vld;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.mod_out   = mod_q;
    assign bus.sog       = out_valid & (grp_pos == '0);
    assign bus.eog       = out_valid & (grp_pos == TW'(P_GRP - 1));
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done;

endmodule

// File: tb/tb_r16_pipe_ctrl.sv
// Randomized bench for r16_pipe_ctrl against a slot-occupancy reference model.
module tb_r16_pipe_ctrl;

    localparam int P = 4;
    localparam int G = 16;
    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_RUN   = 2;
    localparam int S_DRAIN = 3;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;

    r16_pipe_ctrl_if bus ();

    r16_pipe_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: batch phase, counts, and positions of in-flight operands
    // (oldest first); an operand advances when the slot ahead is free.
    int          m_state;
    longint      m_total;
    longint      m_in;
    longint      m_out;
    logic [63:0] m_mod;
    int          pos[$];

    function automatic void model_reset();
        m_state = S_IDLE;
        m_total = 0;
        m_in    = 0;
        m_out   = 0;
        m_mod   = '0;
        pos.delete();
    endfunction

    function automatic logic [P-1:0] mmask();
        logic [P-1:0] m = '0;
        foreach (pos[k]) m[pos[k]] = 1'b1;
        return m;
    endfunction

    function automatic logic [P-1:0] men();
        logic [P-1:0] m = mmask();
        logic [P-1:0] e = '0;
        for (int i = 0; i < P; i++) begin
            bit full = 1;
            for (int j = i; j < P; j++)
                if (!m[j]) full = 0;
            e[i] = !full || bus.out_ready;
        end
        return e;
    endfunction

    // {busy, done, in_ready, out_valid, sog, eog, stage_vld, stage_en}
    function automatic logic [13:0] exp_vec();
        logic [P-1:0] m  = mmask();
        logic [P-1:0] e  = men();
        logic         ov = m[P-1];
        logic         ir = (m_state == S_RUN) && e[0];
        logic         hs = ov && bus.out_ready;
        logic         dn;
        dn = (m_state == S_LOAD && m_total == 0) ||
             (m_state == S_DRAIN && hs && m_out == m_total - 1);
        return {m_state != S_IDLE, dn, ir, ov,
                ov && (m_out % G == 0), ov && (m_out % G == G - 1), m, e};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {bus.busy, bus.done, bus.in_ready, bus.out_valid,
                bus.sog, bus.eog, bus.stage_vld, bus.stage_en};
    endfunction

    function automatic void advance();
        int nq[$];
        int lim = P;
        foreach (pos[k]) begin
            int np;
            if (k == 0 && pos[k] == P - 1 && bus.out_ready) continue;
            np = (pos[k] + 1 < lim) ? pos[k] + 1 : pos[k];
            nq.push_back(np);
            lim = np;
        end
        pos = nq;
    endfunction

    function automatic void model_update();
        logic [13:0] x   = exp_vec();
        logic        acc = x[11] && bus.in_valid;
        logic        hs  = x[10] && bus.out_ready;
        logic        dn  = x[12];
        advance();
        if (acc) begin pos.push_back(0); m_in++; end
        if (hs) m_out++;
        case (m_state)
            S_IDLE: if (bus.start) begin
                m_state = S_LOAD;
                m_mod   = bus.mod_in;
                m_total = longint'(bus.num_grp) * G;
                m_in    = 0;
                m_out   = 0;
            end
            S_LOAD:  m_state = (m_total == 0) ? S_IDLE : S_RUN;
            S_RUN:   if (acc && m_in == m_total) m_state = S_DRAIN;
            S_DRAIN: if (dn) m_state = S_IDLE;
            default: m_state = S_IDLE;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.mod_in    = '0;
        bus.num_grp   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #2;
        n_chk++;
        if (dut_vec() !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b want=0", dut_vec());
        end
        n_chk++;
        if (bus.mod_out !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_mod got=%h want=0", bus.mod_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int first_acc = -1, n_acc = 0, first_ov = -1;
        int sog_c = -1, eog_c = -1, done_c = -1, n_done = 0;
        bus.num_grp   = 16'd1;
        bus.mod_in    = 64'h0123_4567_89ab_cdef;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.start = (c == 0);
            #1;
            n_chk++;
            if (dut_vec() !== exp_vec() || bus.mod_out !== m_mod) begin
                n_bad++;
                $display("FAIL stream c=%0d got=%b/%h want=%b/%h",
                         c, dut_vec(), bus.mod_out, exp_vec(), m_mod);
            end
            if (bus.in_ready && bus.in_valid) begin
                if (first_acc < 0) first_acc = c;
                n_acc++;
            end
            if (bus.out_valid && first_ov < 0) first_ov = c;
            if (bus.sog && sog_c < 0) sog_c = c;
            if (bus.eog) eog_c = c;
            if (bus.done) begin n_done++; done_c = c; end
            tick();
        end
        bus.in_valid = 1'b0;
        n_chk++;
        if (first_acc !== 2) begin n_bad++; $display("FAIL stream_first_acc got=%0d want=2", first_acc); end
        n_chk++;
        if (n_acc !== 16) begin n_bad++; $display("FAIL stream_accepts got=%0d want=16", n_acc); end
        n_chk++;
        if (first_ov !== 6) begin n_bad++; $display("FAIL stream_latency got=%0d want=6", first_ov); end
        n_chk++;
        if (sog_c !== 6) begin n_bad++; $display("FAIL stream_sog got=%0d want=6", sog_c); end
        n_chk++;
        if (eog_c !== 21) begin n_bad++; $display("FAIL stream_eog got=%0d want=21", eog_c); end
        n_chk++;
        if (done_c !== 21 || n_done !== 1) begin
            n_bad++;
            $display("FAIL stream_done got=c%0d/n%0d want=c21/n1", done_c, n_done);
        end
        n_chk++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL stream_idle busy=%b want=0", bus.busy); end
    endtask

    task automatic test_backpressure();
        int k = 0, n_done = 0;
        bit fin = 0;
        bus.num_grp  = 16'd2;
        bus.mod_in   = 64'hdead_beef_0000_1111;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 200 && !fin; c++) begin
            bus.start     = (c == 0);
            bus.out_ready = !(c >= 8 && c < 18);
            #1;
            n_chk++;
            if (dut_vec() !== exp_vec() || bus.mod_out !== m_mod) begin
                n_bad++;
                $display("FAIL bp c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
            end
            if (c == 17) begin
                n_chk++;
                if (bus.stage_vld !== 4'b1111 || bus.in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_full vld=%b rdy=%b want=1111/0", bus.stage_vld, bus.in_ready);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_chk++;
                if (bus.sog !== (k % G == 0) || bus.eog !== (k % G == G - 1)) begin
                    n_bad++;
                    $display("FAIL bp_marker k=%0d sog=%b eog=%b", k, bus.sog, bus.eog);
                end
                k++;
            end
            if (bus.done) begin n_done++; fin = 1; end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_chk++;
        if (k !== 32 || n_done !== 1) begin
            n_bad++;
            $display("FAIL bp_count got=%0d/%0d want=32/1", k, n_done);
        end
    endtask

    task automatic test_bubbles();
        bit saw_alt = 0, fin = 0;
        int n_out = 0;
        bus.num_grp = 16'd1;
        bus.mod_in  = 64'h5555_aaaa_5555_aaaa;
        for (int c = 0; c < 200 && !fin; c++) begin
            bus.start     = (c == 0);
            bus.in_valid  = (c % 2 == 0);
            bus.out_ready = !(c >= 14 && c < 17);
            #1;
            n_chk++;
            if (dut_vec() !== exp_vec() || bus.mod_out !== m_mod) begin
                n_bad++;
                $display("FAIL bubble c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
            end
            if (c < 14 && (bus.stage_vld == 4'b0101 || bus.stage_vld == 4'b1010))
                saw_alt = 1;
            if (c >= 14 && c < 17) begin
                n_chk++;
                if (bus.stage_vld !== 4'b1111 && bus.in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL bubble_ready c=%0d vld=%b rdy=%b want=1", c, bus.stage_vld, bus.in_ready);
                end
            end
            if (bus.out_valid && bus.out_ready) n_out++;
            if (bus.done) fin = 1;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_chk++;
        if (!saw_alt) begin n_bad++; $display("FAIL bubble_alt got=0 want=1"); end
        n_chk++;
        if (n_out !== 16 || !fin) begin
            n_bad++;
            $display("FAIL bubble_count got=%0d/%0d want=16/1", n_out, fin);
        end
    endtask

    task automatic test_zero_groups();
        int done_c = -1, n_done = 0, n_acc = 0;
        bit saw_ov = 0;
        bus.num_grp   = 16'd0;
        bus.mod_in    = 64'hFFFF_FFFF_0000_0001;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.start = (c == 0);
            #1;
            n_chk++;
            if (dut_vec() !== exp_vec() || bus.mod_out !== m_mod) begin
                n_bad++;
                $display("FAIL zero c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
            end
            if (c == 1) begin
                n_chk++;
                if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL zero_load busy=%b want=1", bus.busy); end
            end
            if (bus.done) begin n_done++; done_c = c; end
            if (bus.in_valid && bus.in_ready) n_acc++;
            if (bus.out_valid) saw_ov = 1;
            tick();
        end
        bus.in_valid = 1'b0;
        n_chk++;
        if (done_c !== 1 || n_done !== 1) begin
            n_bad++;
            $display("FAIL zero_done got=c%0d/n%0d want=c1/n1", done_c, n_done);
        end
        n_chk++;
        if (n_acc !== 0 || saw_ov) begin n_bad++; $display("FAIL zero_traffic acc=%0d ov=%b want=0/0", n_acc, saw_ov); end
        n_chk++;
        if (bus.mod_out !== 64'hFFFF_FFFF_0000_0001 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_mod got=%h/%b want=ffffffff00000001/0", bus.mod_out, bus.busy);
        end
    endtask

    task automatic run_batch(input string tag, input int ngrp,
                             input int piv, input int pord, input bit hold);
        int  n_acc = 0, n_out = 0, n_done = 0;
        bit  fin = 0;
        bus.num_grp = 16'(ngrp);
        bus.mod_in  = {$urandom, $urandom};
        for (int c = 0; c < 3000 && !fin; c++) begin
            bus.start = (c == 0) || (hold && (m_state == S_LOAD || m_state == S_RUN));
            if (hold && c == 1) begin
                bus.num_grp = 16'(ngrp + 2);
                bus.mod_in  = ~bus.mod_in;
            end
            bus.in_valid  = ($urandom_range(99) < piv);
            bus.out_ready = ($urandom_range(99) < pord);
            #1;
            n_chk++;
            if (dut_vec() !== exp_vec() || bus.mod_out !== m_mod) begin
                n_bad++;
                $display("FAIL %s c=%0d got=%b/%h want=%b/%h",
                         tag, c, dut_vec(), bus.mod_out, exp_vec(), m_mod);
            end
            if (bus.in_valid && bus.in_ready) n_acc++;
            if (bus.out_valid && bus.out_ready) n_out++;
            if (bus.done) begin n_done++; fin = 1; end
            tick();
        end
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_chk++;
        if (n_acc !== ngrp * G || n_out !== ngrp * G || n_done !== 1) begin
            n_bad++;
            $display("FAIL %s_count acc=%0d out=%0d done=%0d want=%0d/%0d/1",
                     tag, n_acc, n_out, n_done, ngrp * G, ngrp * G);
        end
    endtask

    task automatic test_reset_mid_drain();
        bus.num_grp   = 16'd1;
        bus.mod_in    = 64'h0bad_cafe_0bad_cafe;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 19; c++) begin
            bus.start = (c == 0);
            #1;
            n_chk++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rstmid c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
            end
            tick();
        end
        bus.start = 1'b0;
        #1;
        n_chk++;
        if (bus.stage_vld !== 4'b1110 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre vld=%b busy=%b want=1110/1", bus.stage_vld, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (dut_vec() !== 14'd0 || bus.mod_out !== 64'd0) begin
            n_bad++;
            $display("FAIL rstmid_async got=%b/%h want=0/0", dut_vec(), bus.mod_out);
        end
        model_reset();
        @(posedge clk);
        #1;
        n_chk++;
        if (dut_vec() !== 14'd0) begin
            n_bad++;
            $display("FAIL rstmid_hold got=%b want=0", dut_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_batch("post_reset", 1, 100, 100, 0);
    endtask

    task automatic test_start_ignored();
        run_batch("start_hold", 1, 100, 100, 1);
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++)
            run_batch("random", $urandom_range(3), 40 + $urandom_range(60),
                      40 + $urandom_range(60), 0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubbles();
        test_zero_groups();
        test_reset_mid_drain();
        test_start_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
